// File: rtl/sync_arith_unit_seq_pkg.sv
// Shared types and constants for the sequential arithmetic unit.
package sync_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int STAT_ERR  = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_ZERO = 2;
  localparam int STAT_NEG  = 3;

endpackage

// File: rtl/sync_arith_unit_seq_muldiv_core.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Outputs present the values being written this cycle so the caller can latch
// the final result on the same edge that completes the last iteration.
module seq_muldiv_core #(
  parameter int M = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic           i_is_div,
  input  logic [M-1:0]   i_a_mag,
  input  logic [M-1:0]   i_b_mag,
  output logic           o_done,
  output logic [2*M-1:0] o_prod,
  output logic [M-1:0]   o_quot
);

  localparam int CW = $clog2(M + 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           is_div_q, is_div_d;
  // acc: running product (MUL) or partial remainder in low M+1 bits (DIV)
  logic [2*M-1:0] acc_q, acc_d;
  // sha: multiplicand shifting left (MUL) or dividend/quotient in low M bits (DIV)
  logic [2*M-1:0] sha_q, sha_d;
  // shb: multiplier shifting right (MUL) or held divisor (DIV)
  logic [M-1:0]   shb_q, shb_d;
  logic [M:0]     rem_sh, rem_diff;

  // Next-state for one iteration of the selected algorithm.
  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    sha_d    = sha_q;
    shb_d    = shb_q;
    rem_sh   = {acc_q[M-1:0], sha_q[M-1]};
    rem_diff = rem_sh - {1'b0, shb_q};
    if (i_start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(M);
      is_div_d = i_is_div;
      acc_d    = '0;
      sha_d    = {{M{1'b0}}, i_a_mag};
      shb_d    = i_b_mag;
    end else if (busy_q) begin
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != CW'(1));
      if (is_div_q) begin
        // Borrow out of the trial subtraction means the divisor did not fit.
        if (!rem_diff[M]) begin
          acc_d = {{(M-1){1'b0}}, rem_diff};
          sha_d = {{M{1'b0}}, sha_q[M-2:0], 1'b1};
        end else begin
          acc_d = {{(M-1){1'b0}}, rem_sh};
          sha_d = {{M{1'b0}}, sha_q[M-2:0], 1'b0};
        end
      end else begin
        if (shb_q[0]) acc_d = acc_q + sha_q;
        sha_d = sha_q << 1;
        shb_d = shb_q >> 1;
      end
    end
    o_done = busy_q && (cnt_q == CW'(1));
    o_prod = acc_d;
    o_quot = sha_d[M-1:0];
  end

  // Iteration state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      sha_q    <= '0;
      shb_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      sha_q    <= sha_d;
      shb_q    <= shb_d;
    end
  end

endmodule

// File: rtl/sync_arith_unit_seq.sv
// Signed ADD/SUB/MUL/DIV unit with valid/ready handshake on both sides.
//   state | meaning
//   IDLE  | waiting for a request, o_ready high
//   BUSY  | MUL/DIV iterating in the core, M cycles
//   DONE  | result presented, held until downstream accepts
module sync_arith_unit_seq
  import sync_arith_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_op,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);

  if (N != 2) begin : g_bad_n
    $error("sync_arith_unit_seq: N must be 2");
  end
  if (M < 4 || M > 32) begin : g_bad_m
    $error("sync_arith_unit_seq: M must be in 4..32");
  end

  state_e         state_q, state_d;
  logic           res_neg_q, res_neg_d;
  logic           is_div_q, is_div_d;
  logic [M-1:0]   result_q, result_d;
  logic [3:0]     status_q, status_d;

  op_e            op;
  logic [M-1:0]   a_mag, b_mag, sum, b_eff, quot_s, busy_res;
  logic           sub, addsub_ovf, busy_ovf, core_start, core_done;
  logic [2*M-1:0] core_prod, prod_s;
  logic [M-1:0]   core_quot;
  logic [M:0]     prod_top;

  function automatic logic [3:0] mk_status(logic ovf, logic [M-1:0] r);
    logic [3:0] s;
    s            = '0;
    s[STAT_OVF]  = ovf;
    s[STAT_ZERO] = ~|r;
    s[STAT_NEG]  = r[M-1];
    return s;
  endfunction

  seq_muldiv_core #(.M(M)) u_core (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (core_start),
    .i_is_div (op == OP_DIV),
    .i_a_mag  (a_mag),
    .i_b_mag  (b_mag),
    .o_done   (core_done),
    .o_prod   (core_prod),
    .o_quot   (core_quot)
  );

  // Handshake FSM, operand sign handling and flag generation.
  always_comb begin
    state_d    = state_q;
    res_neg_d  = res_neg_q;
    is_div_d   = is_div_q;
    result_d   = result_q;
    status_d   = status_q;
    core_start = 1'b0;

    op    = op_e'(i_op);
    a_mag = i_arg_A[M-1] ? -i_arg_A : i_arg_A;
    b_mag = i_arg_B[M-1] ? -i_arg_B : i_arg_B;

    sub        = (op == OP_SUB);
    b_eff      = sub ? ~i_arg_B : i_arg_B;
    sum        = sub ? (i_arg_A - i_arg_B) : (i_arg_A + i_arg_B);
    addsub_ovf = (i_arg_A[M-1] == b_eff[M-1]) && (sum[M-1] != i_arg_A[M-1]);

    // Product fits in M signed bits only if its upper M+1 bits are a pure sign extension.
    prod_s   = res_neg_q ? -core_prod : core_prod;
    prod_top = prod_s[2*M-1:M-1];
    quot_s   = res_neg_q ? -core_quot : core_quot;
    // Only -2^(M-1)/-1 yields a positive quotient magnitude with the top bit set.
    busy_res = is_div_q ? quot_s : prod_s[M-1:0];
    busy_ovf = is_div_q ? (!res_neg_q && core_quot[M-1]) : !((&prod_top) || ~(|prod_top));

    o_ready = (state_q == ST_IDLE);
    o_valid = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          res_neg_d = i_arg_A[M-1] ^ i_arg_B[M-1];
          is_div_d  = (op == OP_DIV);
          unique case (op)
            OP_ADD, OP_SUB: begin
              state_d  = ST_DONE;
              result_d = sum;
              status_d = mk_status(addsub_ovf, sum);
            end
            OP_MUL: begin
              state_d    = ST_BUSY;
              core_start = 1'b1;
            end
            OP_DIV: begin
              if (i_arg_B == '0) begin
                state_d            = ST_DONE;
                result_d           = '1;
                status_d           = '0;
                status_d[STAT_ERR] = 1'b1;
              end else begin
                state_d    = ST_BUSY;
                core_start = 1'b1;
              end
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (core_done) begin
          state_d  = ST_DONE;
          result_d = busy_res;
          status_d = mk_status(busy_ovf, busy_res);
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and presented-result registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      res_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
      result_q  <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      res_neg_q <= res_neg_d;
      is_div_q  <= is_div_d;
      result_q  <= result_d;
      status_q  <= status_d;
    end
  end

  assign o_result = result_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_sync_arith_unit_seq.sv
// Directed-vector bench for sync_arith_unit_seq at M=4.
module tb_sync_arith_unit_seq;

  localparam int M = 4;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_op;
  logic [M-1:0] i_arg_A, i_arg_B;
  logic         o_valid;
  logic         i_ready;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;

  int checks   = 0;
  int failures = 0;

  sync_arith_unit_seq #(.M(M), .N(2)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_arg_A  (i_arg_A),
    .i_arg_B  (i_arg_B),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_status (o_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] stat;
    int         lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one request, count edges (accept edge = 1) until o_valid, sample outputs.
  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input bit scramble, output logic [3:0] res, output logic [3:0] stat,
                        output int lat);
    @(negedge clk);
    i_op = op; i_arg_A = a; i_arg_B = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    if (scramble) begin
      i_arg_A = ~a; i_arg_B = 4'b0011; i_op = 2'b00;
    end
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = o_result;
    stat = o_status;
  endtask

  initial begin
    logic [3:0] r, s;
    int lat, vcnt;

    vecs[0]  = '{2'b00, 4'b0011, 4'b0100, 4'b0111, 4'b0000, 1};
    vecs[1]  = '{2'b00, 4'b0111, 4'b0001, 4'b1000, 4'b1010, 1};
    vecs[2]  = '{2'b01, 4'b0011, 4'b0101, 4'b1110, 4'b1000, 1};
    vecs[3]  = '{2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1};
    vecs[4]  = '{2'b01, 4'b1000, 4'b0001, 4'b0111, 4'b0010, 1};
    vecs[5]  = '{2'b10, 4'b1101, 4'b0010, 4'b1010, 4'b1000, 5};
    vecs[6]  = '{2'b10, 4'b0100, 4'b0100, 4'b0000, 4'b0110, 5};
    vecs[7]  = '{2'b10, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 5};
    vecs[8]  = '{2'b10, 4'b1000, 4'b1111, 4'b1000, 4'b1010, 5};
    vecs[9]  = '{2'b10, 4'b0011, 4'b0000, 4'b0000, 4'b0100, 5};
    vecs[10] = '{2'b11, 4'b0111, 4'b1110, 4'b1101, 4'b1000, 5};
    vecs[11] = '{2'b11, 4'b0101, 4'b0000, 4'b1111, 4'b0001, 1};
    vecs[12] = '{2'b11, 4'b1000, 4'b1111, 4'b1000, 4'b1010, 5};
    vecs[13] = '{2'b11, 4'b1001, 4'b0011, 4'b1110, 4'b1000, 5};
    vecs[14] = '{2'b11, 4'b0010, 4'b0101, 4'b0000, 4'b0100, 5};
    vecs[15] = '{2'b11, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 5};
    vecs[16] = '{2'b10, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 5};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_op = 2'b00; i_arg_A = '0; i_arg_B = '0;
    #12;
    chk("rst_o_valid",  int'(o_valid),  0);
    chk("rst_o_ready",  int'(o_ready),  1);
    chk("rst_o_result", int'(o_result), 0);
    chk("rst_o_status", int'(o_status), 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      chk($sformatf("v%0d_ready", i), int'(o_ready), 1);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r, s, lat);
      chk($sformatf("v%0d_lat", i),    lat,     vecs[i].lat);
      chk($sformatf("v%0d_result", i), int'(r), int'(vecs[i].res));
      chk($sformatf("v%0d_status", i), int'(s), int'(vecs[i].stat));
      @(posedge clk); #1;
      chk($sformatf("v%0d_back_idle", i), int'(o_ready), 1);
    end

    // Operands changed after accept must not affect the result.
    run_op(2'b11, 4'b0111, 4'b1110, 1'b1, r, s, lat);
    chk("scr_lat",    lat,     5);
    chk("scr_result", int'(r), 4'b1101);
    chk("scr_status", int'(s), 4'b1000);
    @(posedge clk); #1;

    // Backpressure in DONE with a stray request pulse.
    i_ready = 1'b0;
    run_op(2'b10, 4'b1101, 4'b0010, 1'b0, r, s, lat);
    chk("bp_lat", lat, 5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_valid = (c == 1); i_op = 2'b00; i_arg_A = 4'b0001; i_arg_B = 4'b0001;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c),  int'(o_valid),  1);
      chk($sformatf("bp%0d_ready", c),  int'(o_ready),  0);
      chk($sformatf("bp%0d_result", c), int'(o_result), 4'b1010);
      chk($sformatf("bp%0d_status", c), int'(o_status), 4'b1000);
    end
    @(negedge clk); i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", int'(o_ready), 1);
    chk("bp_release_valid", int'(o_valid), 0);
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (o_valid) vcnt++;
    end
    chk("bp_no_queued", vcnt, 0);

    // Reset during the second BUSY cycle of a MUL.
    @(negedge clk);
    i_op = 2'b10; i_arg_A = 4'b0011; i_arg_B = 4'b0011; i_valid = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_valid",  int'(o_valid),  0);
    chk("mrst_ready",  int'(o_ready),  1);
    chk("mrst_result", int'(o_result), 0);
    chk("mrst_status", int'(o_status), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (o_valid) vcnt++;
    end
    chk("mrst_aborted", vcnt, 0);
    run_op(2'b00, 4'b0010, 4'b0011, 1'b0, r, s, lat);
    chk("post_lat",    lat,     1);
    chk("post_result", int'(r), 4'b0101);
    chk("post_status", int'(s), 4'b0000);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_arith_unit_seq.md
SYNC_ARITH_UNIT_SEQ -- requirements
Module: sync_arith_unit_seq

Interface
REQ-001 Parameter M, default 8: operand/result width in bits, signed two's complement; legal range 4..32.
REQ-002 Parameter N, default 2: opcode width; fixed at 2, other values rejected at elaboration.
REQ-003 i_clk  in  1  single clock, all state rising-edge triggered.
REQ-004 i_reset  in  1  reset, asynchronous and active-high.
REQ-005 i_valid  in  1  operation request from upstream.
REQ-006 o_ready  out  1  unit can accept a request.
REQ-007 i_op  in  N  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 i_arg_A  in  M  operand A (dividend, minuend).
REQ-009 i_arg_B  in  M  operand B (divisor, subtrahend).
REQ-010 o_valid  out  1  result available.
REQ-011 i_ready  in  1  downstream accepts result.
REQ-012 o_result  out  M  result.
REQ-013 o_status  out  4  flags: [0] error, [1] overflow, [2] zero, [3] negative.

Function
REQ-014 FSM states IDLE, BUSY, DONE; o_ready = 1 only in IDLE, combinational from state.
REQ-015 Accept when i_valid && o_ready at a rising edge; A, B, op captured; later input changes ignored until the next accept.
REQ-016 ADD/SUB, and DIV with B = 0: IDLE -> DONE; o_valid high 1 cycle after the accept edge.
REQ-017 MUL/DIV with B != 0: IDLE -> BUSY for exactly M cycles -> DONE; o_valid high M+1 cycles after the accept edge.
REQ-018 DONE: o_valid = 1; o_result/o_status stable while i_ready = 0; on o_valid && i_ready -> IDLE next cycle.
REQ-019 i_valid ignored in BUSY and DONE; no request is queued.
REQ-020 ADD/SUB: M-bit wrap result; overflow = operands' signs (B inverted for SUB) agree and result sign differs.
REQ-021 MUL: iterative shift-add on magnitudes, one bit per BUSY cycle, sign applied at end; result = low M bits of the true product; overflow set when the true product is outside signed M-bit range.
REQ-022 DIV: restoring division on magnitudes, one bit per BUSY cycle; quotient truncates toward zero; remainder discarded.
REQ-023 DIV -2^(M-1) / -1: result -2^(M-1), overflow = 1.
REQ-024 DIV by 0: result all ones, error = 1, all other flags 0.
REQ-025 zero = (o_result == 0), negative = o_result[M-1], except REQ-024.
REQ-026 o_result and o_status update only on entry to DONE and hold until the next DONE entry.

Reset
REQ-027 i_reset asserted: immediately state IDLE, o_valid 0, o_ready 1, o_result 0, o_status 0, iteration counter 0.
REQ-028 Reset during BUSY or DONE aborts the operation; no result is ever presented for it.
REQ-029 First accept possible on the first rising edge after i_reset deasserts.

Structure
REQ-030 Package sync_arith_pkg holds the opcode enum, FSM state enum and o_status bit-index constants.
REQ-031 One sub-module, seq_muldiv_core: iterative MUL/DIV datapath with start/done, M-parameterised; FSM, flags and handshake stay in the top.
REQ-032 Iteration counter width $clog2(M+1); no combinational multiplier or divider.

Verification (M=4)
REQ-033 ADD 0011+0100, i_ready=1 -> o_valid 1 cycle after accept, o_result 0111, o_status 0000; ADD 0111+0001 -> 1000, status 1010.
REQ-034 MUL 1101*0010 (-3*2) -> o_valid 5 cycles after accept, o_result 1010, status 1000; MUL 0100*0100 -> overflow = 1.
REQ-035 DIV 0111/1110 (7/-2) -> 1101, status 1000; DIV 0101/0000 -> 1111, status 0001 after 1 cycle; DIV 1000/1111 -> 1000, status 1010.
REQ-036 Backpressure: i_ready low 3 cycles in DONE with i_valid pulsed -> outputs stable, o_ready 0, pulse ignored; i_ready high -> IDLE and o_ready 1 next cycle.
REQ-037 i_reset pulse at BUSY cycle 2 of MUL -> o_valid 0, o_ready 1, o_result 0000, o_status 0000 before the next edge; new ADD after release completes normally.
REQ-038 Operand change after accept during BUSY -> result reflects the captured operands only.
